// File: rtl/data_mem_responder.sv
// Data-memory responder: captures one load/store, waits WAIT_CYCLES, then pulses a single-cycle response.
// Latency: WAIT_CYCLES+1 cycles from acceptance; no response back-pressure, req_ready low while busy.
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            funct3_q, funct3_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  rerr_q, rerr_d;

   logic [31:0]           mem [DEPTH];

   logic                  unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   function automatic logic access_error(input logic wr, input logic [1:0] a, input logic [2:0] f3);
      logic e;
      case (f3)
         3'b000:  e = 1'b0;
         3'b001:  e = a[0];
         3'b010:  e = (a != 2'b00);
         3'b100:  e = wr;
         3'b101:  e = wr | a[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] a,
                                                input logic [2:0] f3);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shifted = word >> {a, 3'b000};
      b       = shifted[7:0];
      h       = a[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] a, input logic [2:0] f3);
      logic [3:0] be;
      case (f3)
         3'b000:  be = 4'b0001 << a;
         3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // With zero wait states the response is formed at the acceptance edge, so read from the live request.
   logic                  idle;
   logic                  cur_write;
   logic [ADDR_WIDTH+1:0] cur_addr;
   logic [2:0]            cur_funct3;
   logic                  live_err;
   logic                  cur_err;
   logic [31:0]           rd_word;

   assign idle       = (state_q == S_IDLE);
   assign cur_write  = idle ? req_write : write_q;
   assign cur_addr   = idle ? req_addr[ADDR_WIDTH+1:0] : addr_q;
   assign cur_funct3 = idle ? req_funct3 : funct3_q;
   assign live_err   = access_error(req_write, req_addr[1:0], req_funct3);
   assign cur_err    = idle ? live_err : err_q;
   assign rd_word    = mem[cur_addr[ADDR_WIDTH+1:2]];

   always_comb begin
      logic enter_resp;
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      err_d      = err_q;
      rdata_d    = 32'd0;
      rerr_d     = 1'b0;
      enter_resp = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               addr_d   = req_addr[ADDR_WIDTH+1:0];
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               err_d    = live_err;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (enter_resp) begin
         rerr_d  = cur_err;
         rdata_d = (cur_write || cur_err) ? 32'd0 : load_extend(rd_word, cur_addr[1:0], cur_funct3);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         funct3_q <= 3'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

   // Stores commit on the RESP edge; reset on that same edge suppresses the write.
   logic [3:0]  st_be;
   logic [31:0] st_lanes;
   assign st_be    = byte_en(addr_q[1:0], funct3_q);
   assign st_lanes = (funct3_q == 3'b000) ? {4{wdata_q[7:0]}} :
                     (funct3_q == 3'b001) ? {2{wdata_q[15:0]}} : wdata_q;

   always_ff @(posedge CLK) begin
      if (!RESET && state_q == S_RESP && write_q && !err_q) begin
         for (int k = 0; k < 4; k++) begin
            if (st_be[k]) mem[addr_q[ADDR_WIDTH+1:2]][k*8 +: 8] <= st_lanes[k*8 +: 8];
         end
      end
   end

   assign req_ready  = idle && !RESET;
   assign resp_valid = (state_q == S_RESP) && !RESET;
   assign resp_rdata = RESET ? 32'd0 : rdata_q;
   assign resp_error = rerr_q && !RESET;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the core's data-memory load/store interface. Accepts one request at a time from the core's memory stage and inserts a configurable number of wait states. Performs RV32I byte/halfword/word stores with byte lanes and sign/zero-extended loads, then returns a single-cycle response. It sits beside `Core` in the top level and replaces the zero-latency data memory when stall handling is exercised.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: log2 of memory depth in 32-bit words (1024 words = 4 KiB).
- `WAIT_CYCLES`, default 2: wait states between request acceptance and response (0..15).

Ports:
- `CLK`  in  1: the only clock; all logic is on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: core presents a request.
- `req_ready`  out  1: responder can accept a request this cycle.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data; the value is taken from the low bits for SB/SH.
- `req_funct3`  in  3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `resp_valid`  out  1: one-cycle pulse when the request completes.
- `resp_rdata`  out  32: extended load data; 0 for stores and errors.
- `resp_error`  out  1: misaligned access or illegal funct3; valid with `resp_valid`.

## Operation
- Storage: 2**ADDR_WIDTH x 32-bit words. Word index is `req_addr[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses wrap. Contents are not cleared by reset.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture write, addr, wdata and funct3. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: a counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to RESP when it reaches 0.
  - RESP: `resp_valid`=1 for exactly this cycle, then return to IDLE.
- Error check at acceptance:
  - H/HU with addr[0]≠0 is an error.
  - W with addr[1:0]≠0 is an error.
  - funct3 of 011, 110 or 111 is an error.
  - For stores, 100 and 101 are also errors.
  - An erroneous store never modifies memory. An erroneous load returns 0.
- Stores commit in the RESP cycle, using byte enables decoded from funct3 and addr[1:0]:
  - SB writes one lane with wdata[7:0].
  - SH writes lanes {addr[1],0} and +1 with wdata[15:0].
  - SW writes all four lanes.
- Loads read the word in the RESP cycle:
  - Select the byte or halfword by addr[1:0].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- Read-after-write: a load accepted after a store's RESP cycle sees the stored data.

## Timing
- Reset values: `req_ready`=0 during the RESET cycle and 1 from the first cycle after it. `resp_valid`=0, `resp_rdata`=0, `resp_error`=0. FSM is in IDLE and the counter is 0.
- Latency: a request accepted at edge N gives `resp_valid` high during cycle N+1+WAIT_CYCLES.
- There is no response back-pressure; the core must sample the response in the pulse cycle.
- `req_ready` is 0 in WAIT and RESP. Requests presented then are ignored, not queued.
- Back-to-back throughput: one request per WAIT_CYCLES+2 cycles.
- `resp_rdata` and `resp_error` are registered. They hold their value only during the `resp_valid` cycle and are 0 otherwise.
- RESET asserted in WAIT or RESP: return to IDLE and drop the response. A store that has not reached the RESP edge is not written. A store whose RESP edge coincides with RESET is also not written, because reset has priority.
- Input changes after acceptance have no effect, because the request is captured.

## Test plan
- Reset: hold RESET 6 cycles mid-WAIT of a pending SW to 0x10 -> no `resp_valid`, and a later LW 0x10 returns the prior contents. After release, `req_ready`=1 on the next cycle.
- Word round trip: SW 0xDEADBEEF to 0x40, then LW 0x40 -> `resp_rdata`=0xDEADBEEF, `resp_error`=0, response exactly WAIT_CYCLES+1 cycles after each accept.
- Byte/half extension: SW 0x8081F0FF to 0x80, then:
  - LB 0x80 -> 0xFFFFFFFF
  - LBU 0x81 -> 0x000000F0
  - LH 0x82 -> 0xFFFF8081
  - LHU 0x82 -> 0x00008081
- Partial stores: SW 0 to 0x100, SB 0xAB to 0x103, SH 0x1234 to 0x100 -> LW 0x100 returns 0xAB001234.
- Errors: LW 0x41 and SH 0x43 0xFFFF -> `resp_error`=1 and `resp_rdata`=0. LW 0x40 is unchanged. funct3=011 -> error.
- Throughput and boundaries:
  - `req_valid` held high continuously -> accepts spaced WAIT_CYCLES+2 cycles apart.
  - With WAIT_CYCLES=0, the response arrives next cycle.
  - An address at 4*2**ADDR_WIDTH aliases to word 0.
